axi4_bch_fifo: RTL and testbench
================================

# axi4_bch_fifo

Parametrised AXI4 write-response (B) channel buffer for the RAB datapath: a DEPTH-entry FIFO between downstream slave responses (m side) and the upstream master (s side). It adds a non-AXI-violating hold input, a fill-level output and a saturating error-response counter. It sits in the RAB write path where a single register slice is too shallow, for example while miss handling stalls response return.

## Interface
- C_AXI_ID_WIDTH, 4, BID width
- C_AXI_USER_WIDTH, 4, BUSER width
- C_DEPTH, 4, FIFO entries; power of 2, >= 2
- C_CNT_WIDTH, 8, error counter width
- axi4_aclk  in  1  clock; all logic on rising edge
- axi4_arstn  in  1  asynchronous active-low reset
- m_axi4_bid  in  C_AXI_ID_WIDTH  response ID from downstream
- m_axi4_bresp  in  2  response code
- m_axi4_buser  in  C_AXI_USER_WIDTH  user bits
- m_axi4_bvalid  in  1  downstream valid
- m_axi4_bready  out  1  FIFO not full
- s_axi4_bid / s_axi4_bresp / s_axi4_buser  out  as m side  head-of-FIFO entry
- s_axi4_bvalid  out  1  upstream valid
- s_axi4_bready  in  1  upstream ready
- hold  in  1  request to withhold new responses upstream
- err_clr  in  1  synchronous clear of err_cnt
- fill_level  out  $clog2(C_DEPTH)+1  current occupancy, 0..C_DEPTH
- err_cnt  out  C_CNT_WIDTH  count of SLVERR/DECERR delivered upstream

## Operation
- Entry packing: bresp in bits [1:0], bid above it, buser in the MSBs. Total width is C_AXI_ID_WIDTH+C_AXI_USER_WIDTH+2.
- Storage is a circular array with read and write pointers of $clog2(C_DEPTH)+1 bits. The extra bit is the wrap flag.
  - Empty when the pointers are equal.
  - Full when the index bits are equal and the wrap bits differ.
- Push: m_axi4_bvalid & m_axi4_bready. The entry is written at wr_ptr and wr_ptr increments.
- Pop: s_axi4_bvalid & s_axi4_bready. rd_ptr increments.
- m_axi4_bready = !full. It is derived from registered state only, with no combinational path from s_axi4_bready.
- s_axi4_b* data is taken directly from the entry at rd_ptr.
- fill_level is a register: +1 on push only, -1 on pop only, unchanged on both or neither.
- Hold handling:
  - The presented flag is set when s_axi4_bvalid & !s_axi4_bready. It is cleared on pop.
  - s_axi4_bvalid = !empty & (!hold | presented). Hold therefore never retracts an already-asserted valid, as AXI requires.
- Error counter:
  - Increments on a pop with bresp[1]=1 and saturates at all-ones.
  - err_clr has priority: if a clear and an increment occur in the same cycle, the result is 0.
- Reset values:
  - Pointers, fill_level, err_cnt and presented are 0.
  - s_axi4_bvalid is 0 and m_axi4_bready is 1.
  - Storage contents are not reset, and s_axi4_b* data is undefined while empty.
- Reset asserted mid-operation discards all entries immediately. In-flight responses are lost, and the system is responsible for quiescing first.

## Timing
- Latency: a push at edge N makes the entry visible with s_axi4_bvalid=1 after edge N. There is no combinational fall-through when empty.
- Throughput is one response per cycle in steady state.
- When full, m_axi4_bready=0. A same-cycle pop does not enable a same-cycle push; ready rises the cycle after the pop.
- When empty, a push with simultaneous s_axi4_bready=1 does not pop that cycle.
- Pointer wrap is natural modulo 2·C_DEPTH with no special casing.
- Hold asserted while presented=0 masks valid in the same cycle. Deasserting hold re-exposes valid in the same cycle.

## Structure
- Shared package axi_rab_pkg holds:
  - localparam helpers for the B-channel packed width;
  - field-offset constants for bresp, bid and buser;
  - the AXI response-code constants OKAY, EXOKAY, SLVERR and DECERR.
- One sub-module, axi_fifo_rab, provides the generic FIFO (DATA_WIDTH, DEPTH, pointers, full/empty, fill level).
- The top level does the packing and unpacking, the hold/presented logic and the error counter.

## Test plan
- Fill and drain: C_DEPTH=4, s_axi4_bready=0, push 5 responses with IDs 1..5.
  - m_axi4_bready must drop after 4 pushes and fill_level must reach 4.
  - With ready released, IDs 1,2,3,4 must pop in order, then ID 5 is accepted.
- Streaming: continuous m_axi4_bvalid with s_axi4_bready=1.
  - One pop per cycle after a 1-cycle initial latency; fill_level stays at 1.
- Hold: hold=1 before the first push.
  - s_axi4_bvalid must stay 0 with fill_level at 1.
  - Then hold=0 with s_axi4_bready=0, then hold=1: s_axi4_bvalid must remain 1 until the handshake.
- Errors: push bresp sequence 0,2,3,1,2 and drain.
  - err_cnt must reach 3.
  - With C_CNT_WIDTH=2, 5 SLVERR responses must saturate err_cnt at 3.
  - err_clr concurrent with an error pop must give err_cnt=0.
- Wrap and simultaneous push/pop: 3·C_DEPTH transfers with random ready stalls.
  - No loss or reordering per scoreboard; fill_level must always equal pushes minus pops.
- Reset mid-stream: assert axi4_arstn=0 with fill_level=3.
  - s_axi4_bvalid goes 0 immediately; after release fill_level and err_cnt are 0 and m_axi4_bready is 1.

Source files
------------

// File: rtl/axi_rab_pkg.sv
// axi_rab_pkg: shared AXI B-channel field layout and response codes for the RAB datapath
package axi_rab_pkg;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  localparam int BRESP_LSB = 0;
  localparam int BID_LSB = 2;
  function automatic int buser_lsb(input int id_w);
    return BID_LSB + id_w;
  endfunction
  function automatic int b_width(input int id_w, input int user_w);
    return id_w + user_w + 2;
  endfunction
endpackage

// File: rtl/axi_fifo_rab.sv
// axi_fifo_rab: circular FIFO with wrap-flag pointers and a registered fill level
module axi_fifo_rab #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill_level
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) & (wr_ptr[AW] != rd_ptr[AW]);
  assign rdata = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fill_level <= (push & !pop) ? fill_level + 1'b1 : (pop & !push) ? fill_level - 1'b1 : fill_level;
    end
  end
  // storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/axi4_bch_fifo.sv
// axi4_bch_fifo: AXI4 B-channel buffer with hold, fill level and saturating error count
module axi4_bch_fifo
  import axi_rab_pkg::*;
#(
  parameter int C_AXI_ID_WIDTH = 4,
  parameter int C_AXI_USER_WIDTH = 4,
  parameter int C_DEPTH = 4,
  parameter int C_CNT_WIDTH = 8
) (
  input  logic                          axi4_aclk,
  input  logic                          axi4_arstn,
  input  logic [C_AXI_ID_WIDTH-1:0]     m_axi4_bid,
  input  logic [1:0]                    m_axi4_bresp,
  input  logic [C_AXI_USER_WIDTH-1:0]   m_axi4_buser,
  input  logic                          m_axi4_bvalid,
  output logic                          m_axi4_bready,
  output logic [C_AXI_ID_WIDTH-1:0]     s_axi4_bid,
  output logic [1:0]                    s_axi4_bresp,
  output logic [C_AXI_USER_WIDTH-1:0]   s_axi4_buser,
  output logic                          s_axi4_bvalid,
  input  logic                          s_axi4_bready,
  input  logic                          hold,
  input  logic                          err_clr,
  output logic [$clog2(C_DEPTH):0]      fill_level,
  output logic [C_CNT_WIDTH-1:0]        err_cnt
);
  localparam int W = b_width(C_AXI_ID_WIDTH, C_AXI_USER_WIDTH);
  localparam int UL = buser_lsb(C_AXI_ID_WIDTH);
  logic [W-1:0] wdata, rdata;
  logic full, empty, push, pop, presented;
  assign wdata = {m_axi4_buser, m_axi4_bid, m_axi4_bresp};
  assign s_axi4_bresp = rdata[BRESP_LSB +: 2];
  assign s_axi4_bid = rdata[BID_LSB +: C_AXI_ID_WIDTH];
  assign s_axi4_buser = rdata[UL +: C_AXI_USER_WIDTH];
  assign m_axi4_bready = !full;
  // once valid is shown it stays up until the handshake, regardless of hold
  assign s_axi4_bvalid = !empty & (!hold | presented);
  assign push = m_axi4_bvalid & m_axi4_bready;
  assign pop = s_axi4_bvalid & s_axi4_bready;
  axi_fifo_rab #(.DATA_WIDTH(W), .DEPTH(C_DEPTH)) u_fifo (
    .clk(axi4_aclk),
    .rst_n(axi4_arstn),
    .push(push),
    .pop(pop),
    .wdata(wdata),
    .rdata(rdata),
    .full(full),
    .empty(empty),
    .fill_level(fill_level)
  );
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      presented <= 1'b0;
      err_cnt <= '0;
    end else begin
      presented <= pop ? 1'b0 : (s_axi4_bvalid & !s_axi4_bready) ? 1'b1 : presented;
      err_cnt <= err_clr ? '0 : (pop & s_axi4_bresp[1] & ~&err_cnt) ? err_cnt + 1'b1 : err_cnt;
    end
  end
endmodule

// File: tb/tb_axi4_bch_fifo.sv
// tb_axi4_bch_fifo: scoreboard bench for axi4_bch_fifo with directed vectors
module tb_axi4_bch_fifo;
  logic clk = 0, arstn = 0;
  logic [3:0] m_bid = 0, m_buser = 0;
  logic [1:0] m_bresp = 0;
  logic m_bvalid = 0, s_bready = 0, hold = 0, err_clr = 0;
  logic m_bready, s_bvalid, m_bready2, s_bvalid2;
  logic [3:0] s_bid, s_buser, s_bid2, s_buser2;
  logic [1:0] s_bresp, s_bresp2, err2;
  logic [2:0] fill, fill2;
  logic [7:0] err;
  int vecs = 0, errs = 0;
  logic [9:0] sb [$];
  int plog [$];
  int mfill = 0, merr8 = 0, merr2 = 0;
  logic mpres = 0;

  always #5 clk = ~clk;

  axi4_bch_fifo dut (
    .axi4_aclk(clk), .axi4_arstn(arstn),
    .m_axi4_bid(m_bid), .m_axi4_bresp(m_bresp), .m_axi4_buser(m_buser),
    .m_axi4_bvalid(m_bvalid), .m_axi4_bready(m_bready),
    .s_axi4_bid(s_bid), .s_axi4_bresp(s_bresp), .s_axi4_buser(s_buser),
    .s_axi4_bvalid(s_bvalid), .s_axi4_bready(s_bready),
    .hold(hold), .err_clr(err_clr), .fill_level(fill), .err_cnt(err)
  );

  axi4_bch_fifo #(.C_CNT_WIDTH(2)) dut2 (
    .axi4_aclk(clk), .axi4_arstn(arstn),
    .m_axi4_bid(m_bid), .m_axi4_bresp(m_bresp), .m_axi4_buser(m_buser),
    .m_axi4_bvalid(m_bvalid), .m_axi4_bready(m_bready2),
    .s_axi4_bid(s_bid2), .s_axi4_bresp(s_bresp2), .s_axi4_buser(s_buser2),
    .s_axi4_bvalid(s_bvalid2), .s_axi4_bready(s_bready),
    .hold(hold), .err_clr(err_clr), .fill_level(fill2), .err_cnt(err2)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input string n, input int first, input int cnt);
    chk({n, "_count"}, plog.size(), cnt);
    for (int k = 0; k < cnt && k < plog.size(); k++) chk({n, "_order"}, plog[k], (first + k) & 15);
    plog.delete();
  endtask

  task automatic drive(input int id, input logic [1:0] resp);
    m_bvalid = 1;
    m_bid = id[3:0];
    m_buser = ~id[3:0];
    m_bresp = resp;
  endtask

  // monitor: checks handshakes against the scoreboard and tracks the occupancy/error model
  always @(negedge clk) begin
    logic [9:0] e;
    logic popq, pushq;
    if (!arstn) begin
      mfill = 0; mpres = 0; merr8 = 0; merr2 = 0;
      sb.delete();
    end else begin
      chk("fill_level", fill, mfill);
      chk("fill_level_w2", fill2, mfill);
      chk("err_cnt", err, merr8);
      chk("err_cnt_w2", err2, merr2);
      chk("s_bvalid", s_bvalid, mfill != 0 && (!hold || mpres));
      chk("s_bvalid_w2", s_bvalid2, mfill != 0 && (!hold || mpres));
      chk("m_bready", m_bready, mfill != 4);
      popq = s_bvalid && s_bready;
      pushq = m_bvalid && m_bready;
      e = 0;
      if (popq) begin
        if (sb.size() == 0) begin
          vecs++; errs++;
          $display("FAIL pop_on_empty got pop expected none");
        end else begin
          e = sb.pop_front();
          chk("pop_data", {s_buser, s_bid, s_bresp}, e);
          plog.push_back(int'(e[5:2]));
        end
      end
      if (err_clr) begin
        merr8 = 0; merr2 = 0;
      end else if (popq && e[1]) begin
        if (merr8 != 255) merr8++;
        if (merr2 != 3) merr2++;
      end
      mpres = popq ? 0 : (s_bvalid && !s_bready) ? 1 : mpres;
      if (pushq) sb.push_back({m_buser, m_bid, m_bresp});
      mfill = mfill + int'(pushq) - int'(popq);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, cyc;
    logic [1:0] rs [5];
    rs = '{2'd0, 2'd2, 2'd3, 2'd1, 2'd2};
    step(); step();
    chk("rst_s_bvalid", s_bvalid, 0);
    chk("rst_m_bready", m_bready, 1);
    chk("rst_fill", fill, 0);
    chk("rst_err", err, 0);
    arstn = 1;
    step();
    // fill and drain
    for (int i = 1; i <= 4; i++) begin drive(i, 0); step(); end
    chk("full_fill", fill, 4);
    chk("full_ready", m_bready, 0);
    drive(5, 0); step();
    chk("full_hold_fill", fill, 4);
    chk("head_id", s_bid, 1);
    s_bready = 1; step();
    chk("ready_after_pop", m_bready, 1);
    step();
    m_bvalid = 0;
    repeat (4) step();
    chk("drained_fill", fill, 0);
    chk_log("fill_drain", 1, 5);
    // streaming
    for (int i = 0; i < 8; i++) begin
      drive(6 + i, 0); step();
      chk("stream_fill", fill, 1);
    end
    m_bvalid = 0; step(); step();
    chk_log("stream", 6, 8);
    // hold
    s_bready = 0; hold = 1;
    drive(14, 0); step();
    m_bvalid = 0; step();
    chk("hold_masked", s_bvalid, 0);
    chk("hold_fill", fill, 1);
    hold = 0; #1;
    chk("hold_release", s_bvalid, 1);
    step();
    hold = 1; #1;
    chk("hold_presented", s_bvalid, 1);
    step();
    chk("hold_presented2", s_bvalid, 1);
    s_bready = 1; step();
    chk("hold_popped", fill, 0);
    hold = 0;
    chk_log("hold", 14, 1);
    // error counting
    for (int i = 0; i < 5; i++) begin drive(i, rs[i]); step(); end
    m_bvalid = 0; step(); step();
    chk("err_mix", err, 3);
    chk("err_mix_w2", err2, 3);
    for (int i = 0; i < 5; i++) begin drive(i, 2'd2); step(); end
    m_bvalid = 0; step(); step();
    chk("err_count8", err, 8);
    chk("err_sat_w2", err2, 3);
    plog.delete();
    s_bready = 0;
    drive(9, 2'd2); step();
    m_bvalid = 0;
    s_bready = 1; err_clr = 1; step();
    err_clr = 0; s_bready = 0;
    chk("err_clr_prio", err, 0);
    chk("err_clr_prio_w2", err2, 0);
    plog.delete();
    // wrap with random stalls
    sent = 0; cyc = 0;
    while (sent < 12 && cyc < 500) begin
      m_bvalid = $urandom_range(0, 3) != 0;
      m_bid = sent[3:0]; m_buser = ~sent[3:0]; m_bresp = sent[1:0];
      s_bready = $urandom_range(0, 2) != 0;
      if (m_bvalid && m_bready) sent++;
      step(); cyc++;
    end
    chk("wrap_sent", sent, 12);
    m_bvalid = 0; s_bready = 1;
    repeat (10) step();
    chk("wrap_fill", fill, 0);
    chk_log("wrap", 0, 12);
    // reset mid-stream
    s_bready = 0;
    for (int i = 0; i < 3; i++) begin drive(i, 2'd3); step(); end
    m_bvalid = 0;
    chk("pre_rst_fill", fill, 3);
    arstn = 0; #1;
    chk("rst_async_valid", s_bvalid, 0);
    chk("rst_async_fill", fill, 0);
    step();
    arstn = 1; step();
    chk("post_rst_fill", fill, 0);
    chk("post_rst_err", err, 0);
    chk("post_rst_ready", m_bready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
